memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 31 +++
 rtl/memory_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (instruction and data)
// and the single-ported RAM. The master view belongs to the arbiter.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        bus_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access: data has
// priority unless instruction fetch has been starved, with timeout/error abort.
module memory_arbiter #(
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.master  bus
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int SW = ($clog2(STARVE_MAX + 1) > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] starve_cnt;
  logic          bus_err_r;
  logic          dreq;
  logic          dcomp;
  logic          icomp;
  logic          abort;
  logic          grant;

  assign dreq        = bus.dREN | bus.dWEN;
  assign bus.iload   = bus.ramload;
  assign bus.dload   = bus.ramload;
  assign bus.bus_err = bus_err_r;

  always_comb begin
    state_nxt    = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    dcomp        = 1'b0;
    icomp        = 1'b0;
    abort        = 1'b0;
    grant        = 1'b0;
    case (state)
      IDLE: begin
        // A starved instruction fetch overrides the normal data priority.
        if (bus.iREN && starve_cnt == SMAX) begin
          state_nxt = INSTR;
          grant     = 1'b1;
        end else if (dreq) begin
          state_nxt = DATA;
          grant     = 1'b1;
        end else if (bus.iREN) begin
          state_nxt = INSTR;
          grant     = 1'b1;
        end
      end
      DATA: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (!dreq) begin
          state_nxt = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          bus.dwait = 1'b0;
          dcomp     = 1'b1;
          state_nxt = IDLE;
        end else if (bus.ramstate == RAM_ERROR || tcnt >= TLIM) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      INSTR: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        if (!bus.iREN) begin
          state_nxt = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          bus.iwait = 1'b0;
          icomp     = 1'b1;
          state_nxt = IDLE;
        end else if (bus.ramstate == RAM_ERROR || tcnt >= TLIM) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      tcnt       <= '0;
      starve_cnt <= '0;
      bus_err_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        tcnt <= '0;
      end else if (state != IDLE && bus.ramstate != RAM_ACCESS) begin
        tcnt <= tcnt + TW'(1);
      end
      if (abort) begin
        bus_err_r <= 1'b1;
      end
      if (!bus.iREN || icomp) begin
        starve_cnt <= '0;
      end else if (dcomp && starve_cnt < SMAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule
